shift_sequencer: RTL and testbench

//  Multi-cycle shift unit for the core's SLL/SRL/SRA ops; replaces a 32-bit barrel shifter where area matters.

---
 rtl/shift_pkg.sv | 17 +
 rtl/shift_sequencer_if.sv | 19 +
 rtl/shift_step.sv | 22 ++
 rtl/shift_sequencer.sv | 99 +++++++++
 tb/tb_shift_sequencer.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared op and FSM state encodings for the shift sequencer
package shift_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - request/response bundle; kill exists only with SHIFT_KILL_EN
interface shift_sequencer_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;
`ifdef SHIFT_KILL_EN
    logic        kill;

    modport master (output start, op, operand, shamt, kill, input busy, done, result);
    modport slave  (input start, op, operand, shamt, kill, output busy, done, result);
`else
    modport master (output start, op, operand, shamt, input busy, done, result);
    modport slave  (input start, op, operand, shamt, output busy, done, result);
`endif
endinterface

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single step: shift acc by k (k <= STEP) per op
module shift_step
    import shift_pkg::*;
#(
    parameter int KW = 3
) (
    input  logic [31:0]   acc,
    input  op_e           op,
    input  logic          sign,
    input  logic [KW-1:0] k,
    output logic [31:0]   acc_next
);
    logic [63:0] ext;
    logic [31:0] right;

    // Right shifts pull fill bits down from the upper half, so SRA uses the latched sign.
    always_comb begin
        ext      = {((op == OP_SRA) && sign) ? 32'hFFFF_FFFF : 32'h0, acc};
        right    = 32'(ext >> k);
        acc_next = (op == OP_SLL) ? (acc << k) : right;
    end
endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle SLL/SRL/SRA unit, STEP bits per cycle; optional abort via SHIFT_KILL_EN
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int STEP = 4
) (
    input logic              clk,
    input logic              rst,
    shift_sequencer_if.slave bus
);
    localparam int KW = $clog2(STEP + 1);

    state_e        state, state_n;
    logic [31:0]   acc, acc_n, step_out;
    logic [5:0]    rem, rem_n;
    op_e           op_q, op_n;
    logic          sign_q, sign_n;
    logic [31:0]   result_q, result_n;
    logic [KW-1:0] k;
    logic          kill_req;

`ifdef SHIFT_KILL_EN
    assign kill_req = bus.kill;
`else
    assign kill_req = 1'b0;
`endif

    assign k = (int'(rem) < STEP) ? rem[KW-1:0] : KW'(STEP);

    shift_step #(.KW(KW)) u_step (
        .acc      (acc),
        .op       (op_q),
        .sign     (sign_q),
        .k        (k),
        .acc_next (step_out)
    );

    always_comb begin
        state_n  = state;
        acc_n    = acc;
        rem_n    = rem;
        op_n     = op_q;
        sign_n   = sign_q;
        result_n = result_q;
        case (state)
            ST_IDLE: begin
                if (bus.start && !kill_req) begin
                    acc_n  = bus.operand;
                    rem_n  = {1'b0, bus.shamt};
                    op_n   = op_e'(bus.op);
                    sign_n = bus.operand[31];
                    if ((bus.shamt == 5'd0) || (op_e'(bus.op) == OP_RSV)) begin
                        state_n  = ST_DONE;
                        result_n = bus.operand;
                    end else begin
                        state_n = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                // An abort leaves result untouched so the previous answer stays visible.
                if (kill_req) begin
                    state_n = ST_IDLE;
                end else begin
                    acc_n = step_out;
                    rem_n = rem - 6'(k);
                    if (rem == 6'(k)) begin
                        state_n  = ST_DONE;
                        result_n = step_out;
                    end
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            acc      <= '0;
            rem      <= '0;
            op_q     <= OP_SLL;
            sign_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state    <= state_n;
            acc      <= acc_n;
            rem      <= rem_n;
            op_q     <= op_n;
            sign_q   <= sign_n;
            result_q <= result_n;
        end
    end

    assign bus.busy   = (state != ST_IDLE);
    assign bus.done   = (state == ST_DONE);
    assign bus.result = result_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - scoreboard bench over STEP in {1,4,32}; kill cases with SHIFT_KILL_EN
module tb_shift_sequencer;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    localparam int STEPS [3] = '{1, 4, 32};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] operand = '0;
    logic [4:0]  shamt = '0;
    logic        kill_sig = 1'b0;
    bit          mon_en = 1'b0;

    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    exp_t        q [3][$];
    int          bfrom [3];
    int          bto [3];
    int          free_c [3];
    logic [31:0] last_res [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    for (genvar g = 0; g < 3; g++) begin : u
        shift_sequencer_if bus ();
        assign bus.start   = start;
        assign bus.op      = op;
        assign bus.operand = operand;
        assign bus.shamt   = shamt;
`ifdef SHIFT_KILL_EN
        assign bus.kill    = kill_sig;
`endif
        shift_sequencer #(.STEP(STEPS[g])) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        exp_t e;
        logic exp_busy;
        always @(negedge clk) begin
            if (mon_en) begin
                exp_busy = (cyc >= bfrom[g]) && (cyc <= bto[g]);
                checks++;
                if (bus.busy !== exp_busy) begin
                    failures++;
                    $display("FAIL busy step=%0d cyc=%0d got=%b want=%b", STEPS[g], cyc, bus.busy, exp_busy);
                end
                if (bus.done === 1'b1) begin
                    checks++;
                    if (q[g].size() == 0) begin
                        failures++;
                        $display("FAIL spurious_done step=%0d cyc=%0d got=1 want=0", STEPS[g], cyc);
                    end else begin
                        e = q[g].pop_front();
                        if (bus.result !== e.res || cyc != e.cyc) begin
                            failures++;
                            $display("FAIL done step=%0d got=%h@%0d want=%h@%0d", STEPS[g], bus.result, cyc, e.res, e.cyc);
                        end
                        last_res[g] = e.res;
                    end
                end else begin
                    checks++;
                    if (q[g].size() > 0 && q[g][0].cyc <= cyc) begin
                        e = q[g].pop_front();
                        failures++;
                        $display("FAIL missing_done step=%0d cyc=%0d got=0 want=1 (res %h)", STEPS[g], cyc, e.res);
                    end else if (bus.result !== last_res[g]) begin
                        failures++;
                        $display("FAIL result_hold step=%0d cyc=%0d got=%h want=%h", STEPS[g], cyc, bus.result, last_res[g]);
                    end
                end
            end
        end
    end

    function automatic logic [31:0] gold(input logic [1:0] o, input logic [31:0] v, input logic [4:0] sh);
        case (o)
            2'b00:   return v << sh;
            2'b01:   return v >> sh;
            2'b10:   return $signed(v) >>> sh;
            default: return v;
        endcase
    endfunction

    // Drives one cycle of inputs and advances the timing model of each DUT.
    task automatic drive(input bit s, input logic [1:0] o, input logic [31:0] v,
                         input logic [4:0] sh, input bit k, input logic [31:0] e);
        int lat;
        int d;
        exp_t x;
        start = s; op = o; operand = v; shamt = sh; kill_sig = k;
        for (int g = 0; g < 3; g++) begin
            if (kill_sig && cyc >= bfrom[g] && cyc < bto[g]) begin
                void'(q[g].pop_back());
                bto[g]    = cyc;
                free_c[g] = cyc + 1;
            end else if (s && !kill_sig && cyc >= free_c[g]) begin
                lat = (sh == 0 || o == 2'b11) ? 0 : (int'(sh) + STEPS[g] - 1) / STEPS[g];
                d = cyc + 1 + lat;
                x.res = e;
                x.cyc = d;
                q[g].push_back(x);
                bfrom[g]  = cyc + 1;
                bto[g]    = d;
                free_c[g] = d + 1;
            end
        end
        @(posedge clk); #1;
        start = 1'b0; kill_sig = 1'b0;
    endtask

    task automatic settle();
        int mx;
        mx = 0;
        for (int g = 0; g < 3; g++) if (free_c[g] > mx) mx = free_c[g];
        for (int i = 0; i < 100 && cyc < mx + 1; i++) drive(0, 2'b00, '0, '0, 0, '0);
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] v, input logic [4:0] sh, input logic [31:0] e);
        drive(1, o, v, sh, 0, e);
        settle();
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int g = 0; g < 3; g++) begin
            q[g].delete();
            bfrom[g] = 0; bto[g] = -1; free_c[g] = cyc; last_res[g] = '0;
        end
    endtask

    typedef struct {
        logic [1:0]  o;
        logic [31:0] v;
        logic [4:0]  sh;
        logic [31:0] e;
    } vec_t;

    vec_t vecs [12] = '{
        '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000},
        '{2'b10, 32'h8000_00F0, 5'd5,  32'hFC00_0007},
        '{2'b01, 32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFF},
        '{2'b11, 32'h1234_5678, 5'd7,  32'h1234_5678},
        '{2'b01, 32'hF000_0000, 5'd4,  32'h0F00_0000},
        '{2'b00, 32'h0000_00FF, 5'd8,  32'h0000_FF00},
        '{2'b10, 32'h7FFF_0000, 5'd16, 32'h0000_7FFF},
        '{2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF},
        '{2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001},
        '{2'b00, 32'hDEAD_BEEF, 5'd3,  32'hF56D_F778},
        '{2'b10, 32'h8000_0001, 5'd1,  32'hC000_0000},
        '{2'b00, 32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5}
    };

    initial begin
        logic [1:0]  ro;
        logic [31:0] rv;
        logic [4:0]  rs;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int g = 0; g < 3; g++) begin
            bfrom[g] = 0; bto[g] = -1; free_c[g] = cyc; last_res[g] = '0;
        end
        mon_en = 1'b1;
        drive(0, 2'b00, '0, '0, 0, '0);

        foreach (vecs[i]) issue(vecs[i].o, vecs[i].v, vecs[i].sh, vecs[i].e);

        // Start held high: accepted on each IDLE cycle, ignored while busy.
        for (int i = 0; i < 8; i++) drive(1, 2'b00, 32'h0000_0003, 5'd0, 0, 32'h0000_0003);
        settle();
        for (int i = 0; i < 12; i++) drive(1, 2'b00, 32'h0000_0001, 5'd3, 0, 32'h0000_0008);
        settle();

        drive(1, 2'b10, 32'h8000_0000, 5'd31, 0, 32'hFFFF_FFFF);
        do_reset();
        drive(0, 2'b00, '0, '0, 0, '0);
        issue(2'b01, 32'h0000_FF00, 5'd8, 32'h0000_00FF);

`ifdef SHIFT_KILL_EN
        drive(1, 2'b00, 32'h0000_0001, 5'd31, 0, 32'h8000_0000);
        drive(0, 2'b00, '0, '0, 0, '0);
        drive(0, 2'b00, '0, '0, 1, '0);
        settle();
        drive(1, 2'b01, 32'hFFFF_0000, 5'd4, 1, 32'h0FFF_F000);
        settle();
        issue(2'b01, 32'hFFFF_0000, 5'd4, 32'h0FFF_F000);
`endif

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            rv = $urandom;
            rs = 5'($urandom_range(0, 31));
            issue(ro, rv, rs, gold(ro, rv, rs));
        end

        repeat (4) drive(0, 2'b00, '0, '0, 0, '0);
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (q[g].size() != 0) begin
                failures++;
                $display("FAIL pending step=%0d got=%0d want=0", STEPS[g], q[g].size());
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
